// File: rtl/word_32_bit_uart_tx.sv
// Tagged-frame 8N1 UART transmitter: sends a 32-bit word as four tag/data byte pairs, or a command as one pair.
// Optional macro WORD_32_BIT_UART_TX_GAP_EN holds tx idle for GAP_BITS (>= 1) bit-times after every stop bit.
module word_32_bit_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word,
  input  logic        word_valid,
  input  logic [7:0]  cmd,
  input  logic        cmd_valid,
  output logic        ready,
  output logic        tx,
  output logic        done
);

`ifdef WORD_32_BIT_UART_TX_GAP_EN
  localparam int CNT_TOP = (GAP_BITS > 1) ? GAP_BITS * CLKS_PER_BIT : CLKS_PER_BIT;
  localparam int CW      = $clog2(CNT_TOP);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_BITS * CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_GAP} bit_state_t;
`else
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
`endif
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, SEND_TAG, SEND_DATA, FINISH} frame_state_t;

  frame_state_t fstate, fstate_n;
  bit_state_t   bstate, bstate_n;
  logic [1:0]    idx, idx_n;
  logic          is_word, is_word_n;
  logic [31:0]   word_r, word_n;
  logic [7:0]    cmd_r, cmd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;
  logic          byte_end, load;
  logic [7:0]    load_byte;

  assign ready = (fstate == IDLE) || (fstate == FINISH);
  assign done  = (fstate == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate  <= IDLE;
      bstate  <= B_IDLE;
      idx     <= '0;
      is_word <= 1'b0;
      word_r  <= '0;
      cmd_r   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      fstate  <= fstate_n;
      bstate  <= bstate_n;
      idx     <= idx_n;
      is_word <= is_word_n;
      word_r  <= word_n;
      cmd_r   <= cmd_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  // Frame sequencing: the next byte is loaded on the same edge the previous one ends, so bytes abut.
  always_comb begin
    fstate_n  = fstate;
    idx_n     = idx;
    is_word_n = is_word;
    word_n    = word_r;
    cmd_n     = cmd_r;
    load      = 1'b0;
    load_byte = '0;
`ifdef WORD_32_BIT_UART_TX_GAP_EN
    byte_end  = (bstate == B_GAP) && (cnt == GAP_LAST);
`else
    byte_end  = (bstate == B_STOP) && (cnt == BIT_LAST);
`endif
    case (fstate)
      IDLE, FINISH: begin
        fstate_n = IDLE;
        if (word_valid) begin
          fstate_n  = SEND_TAG;
          is_word_n = 1'b1;
          word_n    = word;
          idx_n     = '0;
          load      = 1'b1;
          load_byte = 8'h01;
        end else if (cmd_valid) begin
          fstate_n  = SEND_TAG;
          is_word_n = 1'b0;
          cmd_n     = cmd;
          idx_n     = '0;
          load      = 1'b1;
          load_byte = 8'h00;
        end
      end
      SEND_TAG: begin
        if (byte_end) begin
          fstate_n  = SEND_DATA;
          load      = 1'b1;
          load_byte = is_word ? word_r[{idx, 3'b000} +: 8] : cmd_r;
        end
      end
      SEND_DATA: begin
        if (byte_end) begin
          if (is_word && idx != 2'd3) begin
            fstate_n  = SEND_TAG;
            idx_n     = idx + 2'd1;
            load      = 1'b1;
            load_byte = {6'd0, idx} + 8'd2;
          end else begin
            fstate_n = FINISH;
          end
        end
      end
      default: fstate_n = IDLE;
    endcase
  end

  // Bit serializer: tx_n is the line value for the next cycle, so tx itself is a flop.
  always_comb begin
    bstate_n = bstate;
    cnt_n    = cnt;
    bit_n    = bit_idx;
    shreg_n  = shreg;
    tx_n     = tx;
    if (load) begin
      bstate_n = B_START;
      cnt_n    = '0;
      bit_n    = '0;
      shreg_n  = load_byte;
      tx_n     = 1'b0;
    end else begin
      case (bstate)
        B_START: begin
          if (cnt == BIT_LAST) begin
            bstate_n = B_DATA;
            cnt_n    = '0;
            bit_n    = '0;
            tx_n     = shreg[0];
          end else cnt_n = cnt + CW'(1);
        end
        B_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt_n = '0;
            if (bit_idx == 3'd7) begin
              bstate_n = B_STOP;
              tx_n     = 1'b1;
            end else begin
              bit_n   = bit_idx + 3'd1;
              shreg_n = {1'b0, shreg[7:1]};
              tx_n    = shreg[1];
            end
          end else cnt_n = cnt + CW'(1);
        end
        B_STOP: begin
          tx_n = 1'b1;
          if (cnt == BIT_LAST) begin
            cnt_n = '0;
`ifdef WORD_32_BIT_UART_TX_GAP_EN
            bstate_n = B_GAP;
`else
            bstate_n = B_IDLE;
`endif
          end else cnt_n = cnt + CW'(1);
        end
`ifdef WORD_32_BIT_UART_TX_GAP_EN
        B_GAP: begin
          tx_n = 1'b1;
          if (cnt == GAP_LAST) begin
            cnt_n    = '0;
            bstate_n = B_IDLE;
          end else cnt_n = cnt + CW'(1);
        end
`endif
        default: begin
          bstate_n = B_IDLE;
          cnt_n    = '0;
          tx_n     = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_32_bit_uart_tx.sv
// Randomized bench for word_32_bit_uart_tx: each frame is predicted as a per-cycle tx waveform built from its byte list.
module tb_word_32_bit_uart_tx;
  localparam int C = 4;
`ifdef WORD_32_BIT_UART_TX_GAP_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif
  localparam int BYTE_CYC = (10 + G) * C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word = '0;
  logic        word_valid = 1'b0;
  logic [7:0]  cmd = '0;
  logic        cmd_valid = 1'b0;
  logic        ready, tx, done;

  int vectors = 0;
  int miscompares = 0;

  word_32_bit_uart_tx #(.CLKS_PER_BIT(C), .GAP_BITS(2)) dut (
    .clk(clk), .reset(reset), .word(word), .word_valid(word_valid),
    .cmd(cmd), .cmd_valid(cmd_valid), .ready(ready), .tx(tx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Line level at offset off within one byte slot: start, data LSB first, then stop/gap high.
  function automatic logic exp_bit(input logic [7:0] b, input int off);
    int pos;
    pos = off / C;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    word_valid = 1'b0;
    cmd_valid  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check("idle_tx", tx, 1'b1);
      check("idle_ready", ready, 1'b1);
      check("idle_done", done, 1'b0);
    end
  endtask

  // Caller must be in a cycle with ready=1; leaves the bench in the done cycle.
  task automatic run_frame(input logic wv, input logic cv, input logic [31:0] w, input logic [7:0] c);
    logic [7:0] bytes[$];
    int n;
    bytes = {};
    if (wv) begin
      for (int i = 0; i < 4; i++) begin
        bytes.push_back(8'(i + 1));
        bytes.push_back(w[8*i +: 8]);
      end
    end else begin
      bytes.push_back(8'h00);
      bytes.push_back(c);
    end
    word = w; cmd = c; word_valid = wv; cmd_valid = cv;
    n = bytes.size() * BYTE_CYC;
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      check("tx", tx, exp_bit(bytes[j / BYTE_CYC], j % BYTE_CYC));
      check("busy_ready", ready, 1'b0);
      check("busy_done", done, 1'b0);
      // Busy-time requests and input changes must have no effect.
      word = $urandom; cmd = 8'($urandom);
      word_valid = 1'($urandom); cmd_valid = 1'($urandom);
    end
    word_valid = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("end_done", done, 1'b1);
    check("end_ready", ready, 1'b1);
    check("end_tx", tx, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    reset = 1'b0;
    idle(3);

    run_frame(1'b1, 1'b0, 32'hDEADBEEF, 8'h00);
    idle(5);
    run_frame(1'b0, 1'b1, 32'h0, 8'h5A);
    idle(5);
    run_frame(1'b1, 1'b1, 32'h00000001, 8'hFF);
    idle(100);

    // Contiguous frames, including data bytes equal to tag values.
    run_frame(1'b1, 1'b0, $urandom, 8'h00);
    run_frame(1'b0, 1'b1, 32'h0, 8'($urandom));
    run_frame(1'b1, 1'b0, 32'h04030201, 8'h00);
    idle(3);

    for (int i = 0; i < 6; i++) begin
      logic wv, cv;
      wv = 1'($urandom);
      cv = wv ? 1'($urandom) : 1'b1;
      run_frame(wv, cv, $urandom, 8'($urandom));
      if ($urandom_range(1, 0) == 1) idle($urandom_range(4, 1));
    end
    idle(2);

    // Reset 100 cycles into a word frame abandons it silently.
    word = $urandom; word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    check("start_tx", tx, 1'b0);
    repeat (99) begin
      @(posedge clk); #1;
    end
    check("pre_rst_ready", ready, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_ready", ready, 1'b1);
    check("midrst_done", done, 1'b0);
    reset = 1'b0;
    idle(10);
    run_frame(1'b1, 1'b0, 32'hCAFEF00D, 8'h00);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
